counter_updown_param: RTL and testbench
=======================================

Name: counter_updown_param

Overview:
Parametrised up/down counter that generalises the fixed 8-bit up/down counter.
- Adds a configurable width, modulus and step, plus enable, parallel load, a wrap/saturate mode and terminal-count and wrap indications.
- Used as the general-purpose counter for timers, address generators and BCD/modulo-N digit chains in later labs.
- Single clock domain.

Parameters:
WIDTH, 8, counter width in bits (2..32).
MAX_VAL, 2**WIDTH-1, highest count value. Count range is 0..MAX_VAL (modulus MAX_VAL+1). Must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
STEP, 1, increment/decrement per enabled cycle. Must satisfy 1 <= STEP <= MAX_VAL.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  count enable; count changes only when en=1 (and load=0).
dir  input  1  direction: 1 = up, 0 = down.
sat  input  1  mode: 0 = wrap (modulo), 1 = saturate at 0 / MAX_VAL.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value loaded when load=1.
count  output  WIDTH  registered counter value.
tc  output  1  combinational terminal count.
wrap  output  1  registered one-cycle pulse.

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset is synchronous and active-high on port reset.
- Sampled only at the rising clk edge; no asynchronous path.

Reset:
- count=0, wrap=0 (and ovf_sticky=0 when enabled).

Update priority per rising edge: reset > load > en > hold.
- load=1: count <= min(load_val, MAX_VAL). Values above MAX_VAL clamp to MAX_VAL. wrap <= 0. en and dir are ignored.
- en=1, dir=1 (up), count <= MAX_VAL-STEP: count <= count+STEP, wrap <= 0.
- en=1, dir=1 (up), count > MAX_VAL-STEP:
  - sat=0: count <= count+STEP-(MAX_VAL+1), wrap <= 1.
  - sat=1: count <= MAX_VAL, wrap <= 0.
- en=1, dir=0 (down), count >= STEP: count <= count-STEP, wrap <= 0.
- en=1, dir=0 (down), count < STEP:
  - sat=0: count <= count+(MAX_VAL+1)-STEP, wrap <= 1.
  - sat=1: count <= 0, wrap <= 0.
- en=0, no load: count holds, wrap <= 0.

Other rules:
- Arithmetic is done internally at WIDTH+1 bits, so no intermediate overflow at MAX_VAL = 2**WIDTH-1.
- tc = en & (dir ? (count > MAX_VAL-STEP) : (count < STEP)).
  - tc means the next enabled edge would cross the boundary. It is asserted regardless of sat, for cascading.
  - tc is 0 while en=0.
- wrap pulses only in the cycle after an actual modulo wrap. It never asserts in saturate mode.
- dir and sat may change on any cycle and take effect on the same edge.
- Reset asserted mid-count overrides load and en on that edge.
- count never leaves 0..MAX_VAL, except when MAX_VAL < 2**WIDTH-1 and the count has only been changed through load (load clamps, so this cannot occur).

Optional Feature:
Macro: COUNTER_UPDOWN_STICKY_OVF_EN.

Defined:
- Adds input ovf_clr (1 bit) and output ovf_sticky (1 bit, registered).
- ovf_sticky sets on any edge where en=1, load=0 and the boundary is crossed, whether by wrap or by saturation clip. Saturation clip covers both the up case (count > MAX_VAL-STEP) and the down case (count < STEP).
- It clears on reset or ovf_clr=1. If set and clear occur on the same edge, set wins.
- load does not affect it.

Not defined:
- The ports do not exist.
- All other behaviour is identical.

Test Plan:
1. Defaults (WIDTH=8, MAX_VAL=255, STEP=1): reset=1 for 2 cycles, then en=1, dir=1, sat=0 for 258 cycles.
   - Required: count 0,1,…,255,0,1.
   - tc=1 only while count=255.
   - wrap=1 for exactly one cycle, in the cycle where count=0 after 255.
2. WIDTH=4, MAX_VAL=9, STEP=1 (BCD): load=1, load_val=2; then en=1, dir=0, sat=0.
   - Required: count 2,1,0,9,8.
   - wrap pulses once, after 0→9.
   - load_val=12 loads 9.
3. WIDTH=4, MAX_VAL=9, STEP=3, sat=0: from 0, counting up.
   - Required: count 0,3,6,9,2,5,8,1.
   - wrap pulses after 9→2 and after 8→1.
   - Down from 1: count 1,8.
4. Saturate mode, defaults, sat=1: load 254, up for 3 cycles, then dir=0 after load 1, down for 3 cycles.
   - Required: up sequence 254,255,255,255; down sequence 1,0,0,0.
   - wrap is never 1; tc=1 while held at the boundary.
5. Priority: at count=100, assert reset, load (load_val=7) and en together → count=0. Then load=1 with en=1, load_val=7 → count=7. Then en=0 for 5 cycles → count stays 7, tc=0.
6. With COUNTER_UPDOWN_STICKY_OVF_EN: wrap 255→0 sets ovf_sticky=1, which stays set through further counting and through load.
   - ovf_clr=1 for one cycle → 0.
   - ovf_clr=1 on the same edge as a new wrap → stays 1.

Source files
------------

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter: width, modulus and step are configurable, with load, wrap/saturate mode,
// terminal count and wrap pulse. Optional sticky overflow flag under COUNTER_UPDOWN_STICKY_OVF_EN.
module counter_updown_param #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] STEP    = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
   ,
   input  logic             ovf_clr,
   output logic             ovf_sticky
`endif
);

   // One extra bit keeps count+STEP and count+modulus exact when MAX_VAL is all ones.
   localparam logic [WIDTH:0] MAX_EXT  = {1'b0, MAX_VAL};
   localparam logic [WIDTH:0] STEP_EXT = {1'b0, STEP};
   localparam logic [WIDTH:0] MOD_EXT  = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH:0] UP_LIM   = MAX_EXT - STEP_EXT;

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH:0]   cnt_ext_s;
   logic             up_cross_s, dn_cross_s, cross_s;

   assign cnt_ext_s  = {1'b0, count_q};
   assign up_cross_s = (cnt_ext_s > UP_LIM);
   assign dn_cross_s = (cnt_ext_s < STEP_EXT);
   assign cross_s    = dir ? up_cross_s : dn_cross_s;
   assign tc         = en & cross_s;

   // Next count and wrap pulse: load beats en, en beats hold.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         if (load_val > MAX_VAL) begin
            count_d = MAX_VAL;
         end else begin
            count_d = load_val;
         end
      end else if (en) begin
         if (dir) begin
            if (!up_cross_s) begin
               count_d = WIDTH'(cnt_ext_s + STEP_EXT);
            end else if (sat) begin
               count_d = MAX_VAL;
            end else begin
               count_d = WIDTH'(cnt_ext_s + STEP_EXT - MOD_EXT);
               wrap_d  = 1'b1;
            end
         end else begin
            if (!dn_cross_s) begin
               count_d = WIDTH'(cnt_ext_s - STEP_EXT);
            end else if (sat) begin
               count_d = {WIDTH{1'b0}};
            end else begin
               count_d = WIDTH'(cnt_ext_s + MOD_EXT - STEP_EXT);
               wrap_d  = 1'b1;
            end
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count and wrap registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= {WIDTH{1'b0}};
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;

`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
   logic ovf_q, ovf_d;

   // Sticky flag: any boundary crossing (wrap or clip) sets it; set wins over clear.
   always_comb begin
      ovf_d = ovf_q;
      if (en && !load && cross_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Sticky flag register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf_sticky = ovf_q;
`endif

endmodule

// File: tb/tb_counter_updown_param.sv
// Bench for counter_updown_param: three instances (8-bit default, BCD step 1, mod-10 step 3) checked
// against a plain-arithmetic reference model, directed vectors and random stimulus.
module tb_counter_updown_param;

   logic       clk = 1'b0;
   logic       reset, en, dir, sat, load;
   logic [7:0] lv;
   logic [7:0] cnt0;
   logic [3:0] cnt1, cnt2;
   logic       tc0, tc1, tc2, wr0, wr1, wr2;
`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
   logic       ovf_clr;
   logic       ovf0, ovf1, ovf2;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit mvalid   = 1'b0;

   always #5 clk = ~clk;

   counter_updown_param #(.WIDTH(8)) u_d0 (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .load(load),
      .load_val(lv), .count(cnt0), .tc(tc0), .wrap(wr0)
`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
      , .ovf_clr(ovf_clr), .ovf_sticky(ovf0)
`endif
   );

   counter_updown_param #(.WIDTH(4), .MAX_VAL(4'd9), .STEP(4'd1)) u_d1 (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .load(load),
      .load_val(lv[3:0]), .count(cnt1), .tc(tc1), .wrap(wr1)
`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
      , .ovf_clr(ovf_clr), .ovf_sticky(ovf1)
`endif
   );

   counter_updown_param #(.WIDTH(4), .MAX_VAL(4'd9), .STEP(4'd3)) u_d2 (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .load(load),
      .load_val(lv[3:0]), .count(cnt2), .tc(tc2), .wrap(wr2)
`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
      , .ovf_clr(ovf_clr), .ovf_sticky(ovf2)
`endif
   );

   typedef struct {
      bit          rst, ld, en, dir, sat, clr;
      logic [7:0]  lv;
      int          sel;
      int unsigned ecnt;
      bit          ewr, etc;
   } vec_t;

   typedef struct {
      int unsigned cnt;
      bit          wr;
      bit          ovf;
   } mstate_t;

   mstate_t m [3];

   function automatic vec_t mk(input bit rst, input bit ld, input bit e, input bit d, input bit sa,
                               input bit cl, input logic [7:0] l, input int sel,
                               input int unsigned ec, input bit ew, input bit et);
      vec_t v;
      v.rst = rst; v.ld = ld; v.en = e; v.dir = d; v.sat = sa; v.clr = cl; v.lv = l;
      v.sel = sel; v.ecnt = ec; v.ewr = ew; v.etc = et;
      return v;
   endfunction

   function automatic int unsigned p_max(input int i);
      return (i == 0) ? 255 : 9;
   endfunction

   function automatic int unsigned p_step(input int i);
      return (i == 2) ? 3 : 1;
   endfunction

   // Reference model: modular counting from the behavioural rules, in plain integers.
   function automatic mstate_t ref_next(input mstate_t s, input int i, input vec_t v);
      mstate_t     r;
      int unsigned mx, st, l, nxt;
      bit          crossed;
      mx = p_max(i); st = p_step(i);
      l  = (i == 0) ? int'(v.lv) : int'(v.lv & 8'h0F);
      r = s; r.wr = 1'b0; crossed = 1'b0;
      if (v.rst) begin
         r.cnt = 0; r.ovf = 1'b0;
         return r;
      end
      if (v.ld) begin
         r.cnt = (l > mx) ? mx : l;
      end else if (v.en && v.dir) begin
         nxt = s.cnt + st;
         if (nxt > mx) begin
            crossed = 1'b1;
            if (v.sat) r.cnt = mx;
            else begin r.cnt = nxt - (mx + 1); r.wr = 1'b1; end
         end else r.cnt = nxt;
      end else if (v.en) begin
         if (s.cnt < st) begin
            crossed = 1'b1;
            if (v.sat) r.cnt = 0;
            else begin r.cnt = s.cnt + (mx + 1) - st; r.wr = 1'b1; end
         end else r.cnt = s.cnt - st;
      end
      if (crossed) r.ovf = 1'b1;
      else if (v.clr) r.ovf = 1'b0;
      return r;
   endfunction

   function automatic bit ref_tc(input mstate_t s, input int i, input bit e, input bit d);
      if (!e) return 1'b0;
      return d ? (s.cnt + p_step(i) > p_max(i)) : (s.cnt < p_step(i));
   endfunction

   function automatic logic [63:0] get_cnt(input int i);
      case (i)
         0:       return {56'd0, cnt0};
         1:       return {60'd0, cnt1};
         default: return {60'd0, cnt2};
      endcase
   endfunction

   function automatic logic get_tc(input int i);
      case (i)
         0:       return tc0;
         1:       return tc1;
         default: return tc2;
      endcase
   endfunction

   function automatic logic get_wr(input int i);
      case (i)
         0:       return wr0;
         1:       return wr1;
         default: return wr2;
      endcase
   endfunction

`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
   function automatic logic get_ovf(input int i);
      case (i)
         0:       return ovf0;
         1:       return ovf1;
         default: return ovf2;
      endcase
   endfunction
`endif

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one vector, check tc before the edge, then state after it.
   task automatic apply(input vec_t v);
      reset = v.rst; load = v.ld; en = v.en; dir = v.dir; sat = v.sat; lv = v.lv;
`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
      ovf_clr = v.clr;
`endif
      #1;
      if (mvalid)
         for (int i = 0; i < 3; i++)
            chk($sformatf("tc_pre_d%0d", i), {63'd0, get_tc(i)}, {63'd0, ref_tc(m[i], i, v.en, v.dir)});
      @(posedge clk);
      for (int i = 0; i < 3; i++) m[i] = ref_next(m[i], i, v);
      if (v.rst) mvalid = 1'b1;
      #1;
      if (mvalid) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("count_d%0d", i), get_cnt(i), 64'(m[i].cnt));
            chk($sformatf("wrap_d%0d", i), {63'd0, get_wr(i)}, {63'd0, m[i].wr});
            chk($sformatf("tc_post_d%0d", i), {63'd0, get_tc(i)}, {63'd0, ref_tc(m[i], i, v.en, v.dir)});
`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
            chk($sformatf("ovf_d%0d", i), {63'd0, get_ovf(i)}, {63'd0, m[i].ovf});
`endif
         end
      end
      if (v.sel >= 0) begin
         chk($sformatf("vec_count_d%0d", v.sel), get_cnt(v.sel), 64'(v.ecnt));
         chk($sformatf("vec_wrap_d%0d", v.sel), {63'd0, get_wr(v.sel)}, {63'd0, v.ewr});
         chk($sformatf("vec_tc_d%0d", v.sel), {63'd0, get_tc(v.sel)}, {63'd0, v.etc});
      end
   endtask

   vec_t tbl[$];
   vec_t rv;

   initial begin
      reset = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b0; sat = 1'b0; lv = 8'd0;
`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
      ovf_clr = 1'b0;
`endif
      for (int i = 0; i < 3; i++) begin m[i].cnt = 0; m[i].wr = 1'b0; m[i].ovf = 1'b0; end
      #2;

      // Defaults: reset, then a full up-count through the wrap.
      apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 0, 1'b0, 1'b0));
      apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 0, 1'b0, 1'b0));
      for (int k = 1; k <= 258; k++)
         apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 0, k % 256, k == 256, (k % 256) == 255));

      // BCD down-count with load and clamp.
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2,  1, 2, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1, 1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1, 0, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1, 9, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1, 8, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd12, 1, 9, 1'b0, 1'b0));
      // Mod-10 step-3 counting up then down.
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2, 0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2, 3, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2, 6, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2, 9, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2, 2, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2, 5, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2, 8, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2, 1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2, 8, 1'b1, 1'b0));
      // Saturation at both ends.
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd254, 0, 254, 1'b0, 1'b0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 0, 255, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 0, 1, 1'b0, 1'b0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 0, 0, 1'b0, 1'b1));
      // Priority: reset > load > en > hold.
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd100, 0, 100, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd7,   0, 0,   1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd7,   0, 7,   1'b0, 1'b0));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 0, 7, 1'b0, 1'b0));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
      // Sticky overflow: set by wrap, survives counting and load, cleared by ovf_clr, set beats clear.
      apply(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd254, 0, 254, 1'b0, 1'b0)); chk("seq_ovf0", {63'd0, ovf0}, 64'd0);
      apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   0, 255, 1'b0, 1'b1)); chk("seq_ovf1", {63'd0, ovf0}, 64'd0);
      apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   0, 0,   1'b1, 1'b0)); chk("seq_ovf2", {63'd0, ovf0}, 64'd1);
      apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   0, 1,   1'b0, 1'b0)); chk("seq_ovf3", {63'd0, ovf0}, 64'd1);
      apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd10,  0, 10,  1'b0, 1'b0)); chk("seq_ovf4", {63'd0, ovf0}, 64'd1);
      apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   0, 10,  1'b0, 1'b0)); chk("seq_ovf5", {63'd0, ovf0}, 64'd0);
      apply(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 0, 255, 1'b0, 1'b1)); chk("seq_ovf6", {63'd0, ovf0}, 64'd0);
      apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0,   0, 0,   1'b1, 1'b0)); chk("seq_ovf7", {63'd0, ovf0}, 64'd1);
`endif

      // Random stimulus against the reference model.
      for (int k = 0; k < 400; k++) begin
         rv = mk(($urandom_range(49) == 0), ($urandom_range(9) == 0), ($urandom_range(3) != 0),
                 1'($urandom), 1'($urandom), ($urandom_range(7) == 0), 8'($urandom), -1, 0, 1'b0, 1'b0);
         apply(rv);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
